// File: rtl/if_stage.sv
// if_stage: instruction fetch stage feeding id_stage.
//   Owns the PC and issues 32-bit fetch requests (at most one outstanding). Responses are
//   queued in a small FIFO and presented as {inst, inst_addr} with valid/ready to decode.
//   A redirect flushes the queue and drops any response still in flight.
// Ports:
//   i_clk, i_rst_n                       clock (rising edge), async active-low reset
//   o_inst_req_valid/addr, i_inst_req_ready   fetch request channel (addr 4-byte aligned)
//   i_inst_resp_valid/data               in-order fetch response (one per accepted request)
//   i_redirect_valid/pc                  redirect from execute (1-cycle pulse)
//   o_out_valid, i_out_ready             FIFO head handshake toward decode
//   o_inst, o_inst_addr                  FIFO head instruction and its PC
//   o_fetch_misalign                     sticky: last redirect target was not 4-byte aligned
module if_stage #(
  parameter logic [63:0] RESET_PC   = 64'h0000_0000_8000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_inst_req_valid,
  output logic [63:0] o_inst_req_addr,
  input  logic        i_inst_req_ready,
  input  logic        i_inst_resp_valid,
  input  logic [31:0] i_inst_resp_data,
  input  logic        i_redirect_valid,
  input  logic [63:0] i_redirect_pc,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic [31:0] o_inst,
  output logic [63:0] o_inst_addr,
  output logic        o_fetch_misalign
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] CntFull = CntW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDrop} state_e;

  state_e          r_state;
  state_e          w_state_next;
  logic [63:0]     r_pc;
  logic [63:0]     r_req_pc;
  logic            r_misalign;
  logic [31:0]     r_fifo_inst [FIFO_DEPTH];
  logic [63:0]     r_fifo_addr [FIFO_DEPTH];
  logic [PtrW-1:0] r_wptr;
  logic [PtrW-1:0] r_rptr;
  logic [CntW-1:0] r_count;

  logic w_req_valid;
  logic w_hs;
  logic w_push;
  logic w_pop;

  // Output decode: a request needs a free FIFO slot so the eventual push can never overflow.
  always_comb begin
    w_req_valid = 1'b0;
    case (r_state)
      StReq:   w_req_valid = (r_count < CntFull) && !r_misalign;
      default: w_req_valid = 1'b0;
    endcase
  end

  assign w_hs   = w_req_valid & i_inst_req_ready;
  // Redirect kills both the response in this cycle and any pop of the old stream.
  assign w_push = (r_state == StWait) & i_inst_resp_valid & ~i_redirect_valid;
  assign w_pop  = o_out_valid & i_out_ready & ~i_redirect_valid;

  // Next state: a redirect goes to StDrop whenever a response is still owed by memory.
  always_comb begin
    w_state_next = r_state;
    if (i_redirect_valid) begin
      if (w_hs || (((r_state == StWait) || (r_state == StDrop)) && !i_inst_resp_valid)) begin
        w_state_next = StDrop;
      end else begin
        w_state_next = StReq;
      end
    end else begin
      case (r_state)
        StIdle:         w_state_next = StReq;
        StReq:          if (w_hs) w_state_next = StWait;
        StWait, StDrop: if (i_inst_resp_valid) w_state_next = StReq;
        default:        w_state_next = StIdle;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // PC, request PC and misalign flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc       <= RESET_PC;
      r_req_pc   <= '0;
      r_misalign <= 1'b0;
    end else if (i_redirect_valid) begin
      r_pc       <= i_redirect_pc;
      r_misalign <= |i_redirect_pc[1:0];
    end else if (w_hs) begin
      r_req_pc <= r_pc;
      r_pc     <= r_pc + 64'd4;
    end
  end

  // Fetched-instruction FIFO; a redirect flushes it at the same edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        r_fifo_inst[i] <= '0;
        r_fifo_addr[i] <= '0;
      end
    end else if (i_redirect_valid) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_fifo_inst[r_wptr] <= i_inst_resp_data;
        r_fifo_addr[r_wptr] <= r_req_pc;
        r_wptr              <= r_wptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PtrW'(1);
      end
      r_count <= r_count + CntW'(w_push) - CntW'(w_pop);
    end
  end

  assign o_inst_req_valid = w_req_valid;
  assign o_inst_req_addr  = r_pc;
  assign o_out_valid      = (r_count != '0);
  assign o_inst           = r_fifo_inst[r_rptr];
  assign o_inst_addr      = r_fifo_addr[r_rptr];
  assign o_fetch_misalign = r_misalign;

endmodule
